// File: rtl/fanout_pkg.sv
// Shared helpers for the fanout pipeline tree: tree-shape constant functions
// and the flat-bus slice offset helper.
package fanout_pkg;

  function automatic int unsigned pow_u(int unsigned base, int unsigned exp);
    int unsigned acc;
    acc = 1;
    for (int unsigned i = 0; i < exp; i++) begin
      acc = acc * base;
    end
    return acc;
  endfunction

  // Smallest L with b^L >= n.
  function automatic int unsigned clog_base(int unsigned n, int unsigned b);
    int unsigned lvl;
    int unsigned p;
    lvl = 0;
    p   = 1;
    for (int i = 0; i < 32; i++) begin
      if (p < n) begin
        p   = p * b;
        lvl = lvl + 1;
      end
    end
    return lvl;
  endfunction

  function automatic int unsigned nodes_at(int unsigned level, int unsigned n_out,
                                           int unsigned fanout);
    int unsigned div;
    div = pow_u(fanout, clog_base(n_out, fanout) - level);
    return (n_out + div - 1) / div;
  endfunction

  function automatic int unsigned slice_lo(int unsigned idx, int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fanout_stage.sv
// One non-leaf tree level: a shared valid bit plus N_NODES data copies, each
// fed from parent node j/MAX_FANOUT. Loads whenever empty or draining downstream.
module fanout_stage
  import fanout_pkg::*;
#(
  parameter int unsigned DATA_W     = 1,
  parameter int unsigned N_IN       = 1,
  parameter int unsigned N_NODES    = 1,
  parameter int unsigned MAX_FANOUT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      down_load_i,
  input  logic                      up_valid_i,
  input  logic [N_IN*DATA_W-1:0]    up_data_i,
  output logic                      load_o,
  output logic                      valid_o,
  output logic [N_NODES*DATA_W-1:0] data_o
);

  logic                      valid_q, valid_d;
  logic [N_NODES*DATA_W-1:0] data_q, data_d;

  // Bubble-collapsing: an empty level always takes whatever is upstream.
  assign load_o = !valid_q || down_load_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        for (int unsigned j = 0; j < N_NODES; j++) begin
          data_d[slice_lo(j, DATA_W) +: DATA_W] =
            up_data_i[slice_lo(j / MAX_FANOUT, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fanout_pipe_tree.sv
// Registered broadcast tree: one input word to N_OUT leaves with at most
// MAX_FANOUT loads per node, eager per-leaf handshakes, polarity and enable masks.
module fanout_pipe_tree
  import fanout_pkg::*;
#(
  parameter int unsigned     DATA_W     = 1,
  parameter int unsigned     N_OUT      = 20,
  parameter int unsigned     MAX_FANOUT = 5,
  parameter logic [N_OUT-1:0] INV_MASK  = {N_OUT{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [N_OUT-1:0]        leaf_en,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data
);

  localparam int unsigned LEVELS = clog_base(N_OUT, MAX_FANOUT);
  localparam int unsigned BUS_W  = N_OUT * DATA_W;

  wire [LEVELS:0]              lvl_load;
  wire [LEVELS-1:0]            lvl_valid;
  wire [LEVELS-1:0][BUS_W-1:0] lvl_data;

  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    localparam int unsigned N_NODES = nodes_at(g, N_OUT, MAX_FANOUT);
    localparam int unsigned N_IN    = nodes_at((g == 0) ? 0 : g - 1, N_OUT, MAX_FANOUT);

    logic                   up_valid;
    logic [N_IN*DATA_W-1:0] up_data;

    if (g == 0) begin : g_root
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_inner
      assign up_valid = lvl_valid[g-1];
      assign up_data  = lvl_data[g-1][N_IN*DATA_W-1:0];
    end

    fanout_stage #(
      .DATA_W    (DATA_W),
      .N_IN      (N_IN),
      .N_NODES   (N_NODES),
      .MAX_FANOUT(MAX_FANOUT)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .down_load_i(lvl_load[g+1]),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .load_o     (lvl_load[g]),
      .valid_o    (lvl_valid[g]),
      .data_o     (lvl_data[g][N_NODES*DATA_W-1:0])
    );

    // Upper part of the shared level bus is padding for narrower levels.
    if (N_NODES < N_OUT) begin : g_pad
      assign lvl_data[g][BUS_W-1:N_NODES*DATA_W] = '0;
    end
  end

  logic unused_pad;
  assign unused_pad = ^lvl_data;

  logic [N_OUT-1:0] pending_q, pending_d;
  logic [BUS_W-1:0] leaf_data_q, leaf_data_d;
  logic             leaf_free;
  logic             leaf_load;

  // Free once every still-pending leaf is handshaking this cycle.
  assign leaf_free          = (pending_q & ~out_ready) == '0;
  assign leaf_load          = lvl_valid[LEVELS-1] && leaf_free;
  assign lvl_load[LEVELS]   = leaf_load;

  always_comb begin
    pending_d   = pending_q & ~out_ready;
    leaf_data_d = leaf_data_q;
    if (leaf_load) begin
      pending_d = leaf_en;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (leaf_en[i]) begin
          leaf_data_d[slice_lo(i, DATA_W) +: DATA_W] =
            lvl_data[LEVELS-1][slice_lo(i / MAX_FANOUT, DATA_W) +: DATA_W]
            ^ {DATA_W{INV_MASK[i]}};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      leaf_data_q <= '0;
    end else begin
      pending_q   <= pending_d;
      leaf_data_q <= leaf_data_d;
    end
  end

  assign in_ready  = !rst && lvl_load[0];
  assign out_valid = pending_q;
  assign out_data  = leaf_data_q;

endmodule
